// File: rtl/iob_dbus_wbuf_if.sv
// CPU/memory data bus bundle: request (avalid/address/wdata/wstrb) and response (rdata/rvalid/ready).
// The master drives the request; the slave answers with ready and, for reads, rdata/rvalid.
interface iob_dbus_wbuf_if #(
   parameter int ADDR_W = 32
);
   logic              avalid;
   logic [ADDR_W-1:0] address;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic [31:0]       rdata;
   logic              rvalid;
   logic              ready;

   modport master (output avalid, address, wdata, wstrb, input rdata, rvalid, ready);
   modport slave  (input avalid, address, wdata, wstrb, output rdata, rvalid, ready);
endinterface

// File: rtl/iob_dbus_wbuf.sv
// Posted-write buffer: writes are acked on entry (0 cycles) and drain in order. Reads wait for an empty FIFO, then go out one at a time (>= 4 cycles).
// Backpressure: a write stalls while the FIFO is full. Optional stall counter: IOB_DBUS_WBUF_STALL_CNT_EN.
module iob_dbus_wbuf #(
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           cke_i,
   iob_dbus_wbuf_if.slave  s,
   iob_dbus_wbuf_if.master m
`ifdef IOB_DBUS_WBUF_STALL_CNT_EN
   ,
   output logic [31:0]    stall_cnt_o
`endif
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   ONE_CNT  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = DEPTH_LOG2'(1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        wstrb;
   } entry_t;

   typedef enum logic [2:0] {IDLE, RD_DRAIN, RD_REQ, RD_WAIT, RD_RESP} state_t;

   state_t                state;
   entry_t                fifo_mem [DEPTH];
   entry_t                head;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic [ADDR_W-1:0]     rd_addr;
   logic [31:0]           rd_data;
   logic                  rd_req;
   logic                  rd_resp;
   logic                  full;
   logic                  empty;
   logic                  drain_phase;
   logic                  wr_acc;
   logic                  deq;

   assign full        = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign drain_phase = (state == IDLE) || (state == RD_DRAIN);
   assign head        = fifo_mem[rd_ptr];

   // Acceptance looks only at registered full, never at m.ready, so a dequeue
   // in the same cycle cannot open a slot for the waiting write.
   assign wr_acc = cke_i & ~rst_i & s.avalid & (|s.wstrb) & ~full & (state == IDLE);
   assign deq    = cke_i & ~rst_i & drain_phase & ~empty & m.ready;

   assign s.ready  = wr_acc | rd_resp;
   assign s.rvalid = rd_resp;
   assign s.rdata  = rd_data;

   always_comb begin
      m.avalid  = 1'b0;
      m.address = '0;
      m.wdata   = '0;
      m.wstrb   = '0;
      if (rd_req) begin
         m.avalid  = 1'b1;
         m.address = rd_addr;
      end else if (drain_phase && !empty) begin
         m.avalid  = 1'b1;
         m.address = head.addr;
         m.wdata   = head.wdata;
         m.wstrb   = head.wstrb;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_acc) begin
         fifo_mem[wr_ptr] <= '{addr: s.address, wdata: s.wdata, wstrb: s.wstrb};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         rd_addr <= '0;
         rd_data <= '0;
         rd_req  <= 1'b0;
         rd_resp <= 1'b0;
      end else if (cke_i) begin
         if (wr_acc) wr_ptr <= wr_ptr + ONE_PTR;
         if (deq)    rd_ptr <= rd_ptr + ONE_PTR;
         case ({wr_acc, deq})
            2'b10:   count <= count + ONE_CNT;
            2'b01:   count <= count - ONE_CNT;
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (s.avalid && s.wstrb == 4'b0000) begin
                  state   <= RD_DRAIN;
                  rd_addr <= s.address;
               end
            end
            RD_DRAIN: begin
               // Leave as soon as the last buffered write is handed off.
               if (empty || (count == ONE_CNT && deq)) begin
                  state  <= RD_REQ;
                  rd_req <= 1'b1;
               end
            end
            RD_REQ: begin
               if (m.ready) begin
                  state  <= RD_WAIT;
                  rd_req <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (m.rvalid) begin
                  state   <= RD_RESP;
                  rd_data <= m.rdata;
                  rd_resp <= 1'b1;
               end
            end
            RD_RESP: begin
               state   <= IDLE;
               rd_resp <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               rd_req  <= 1'b0;
               rd_resp <= 1'b0;
            end
         endcase
      end
   end

`ifdef IOB_DBUS_WBUF_STALL_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
      end else if (cke_i && s.avalid && !s.ready && stall_cnt_o != 32'hFFFF_FFFF) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif
endmodule
